game_flow_ctrl: RTL and testbench

//  Top-level game sequencer for the ping-pong design. Walks MENU -> PLAY -> POINT -> OVER (continue screen) and back.

---
 rtl/game_flow_ctrl_pkg.sv | 20 ++
 rtl/game_flow_ctrl_if.sv | 41 ++++
 rtl/game_flow_ctrl_btn_edge.sv | 22 ++
 rtl/game_flow_ctrl.sv | 134 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the ping-pong game sequencer: state encodings,
// colour constants, score width and a saturating score increment.
package game_pkg;

  typedef enum logic [1:0] {
    ST_MENU  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_POINT = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam logic [11:0] BLACK   = 12'h000;
  localparam int          SCORE_W = 4;

  // Scores stop at the top of their range instead of wrapping to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle of everything the sequencer exchanges with the screen blocks, buttons and VGA path.
// slave is the sequencer side; master is whoever drives the inputs and consumes the outputs.
interface game_flow_ctrl_if;
  logic        p_tick;
  logic        frame_tick;
  logic        up1;
  logic        down1;
  logic        enter;
  logic        point_p1;
  logic        point_p2;
  logic        yes;
  logic        no;
  logic [11:0] rgb_menu;
  logic [11:0] rgb_game;
  logic [11:0] rgb_continue;
  logic        up_p;
  logic        down_p;
  logic        enter_p;
  logic        game_reset;
  logic        game_run;
  logic        cont_reset;
  logic        won;
  logic [3:0]  score1;
  logic [3:0]  score2;
  logic [1:0]  state;
  logic [11:0] rgb;

  modport slave (
    input  p_tick, frame_tick, up1, down1, enter, point_p1, point_p2, yes, no,
           rgb_menu, rgb_game, rgb_continue,
    output up_p, down_p, enter_p, game_reset, game_run, cont_reset, won,
           score1, score2, state, rgb
  );

  modport master (
    output p_tick, frame_tick, up1, down1, enter, point_p1, point_p2, yes, no,
           rgb_menu, rgb_game, rgb_continue,
    input  up_p, down_p, enter_p, game_reset, game_run, cont_reset, won,
           score1, score2, state, rgb
  );
endinterface

// File: rtl/game_flow_ctrl_btn_edge.sv
// Rising-edge detector: a level held high for any number of cycles yields one
// registered single-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: MENU -> PLAY -> POINT -> OVER, button edge pulses,
// score keeping, sub-block reset control and the registered VGA colour mux.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = 5,
  parameter int PAUSE_FRAMES = 60
) (
  input logic            clk,
  input logic            reset,
  game_flow_ctrl_if.slave bus
);

  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

  state_t              state;
  logic [SCORE_W-1:0]  score1, score2;
  logic [SCORE_W-1:0]  inc1, inc2;
  logic [7:0]          frame_cnt;
  logic                won, game_reset, game_run, cont_reset;
  logic                up_p, down_p, enter_p;
  logic [11:0]         rgb;

  btn_edge u_up    (.clk(clk), .reset(reset), .level(bus.up1),   .pulse(up_p));
  btn_edge u_down  (.clk(clk), .reset(reset), .level(bus.down1), .pulse(down_p));
  btn_edge u_enter (.clk(clk), .reset(reset), .level(bus.enter), .pulse(enter_p));

  assign inc1 = sat_inc(score1);
  assign inc2 = sat_inc(score2);

  // Sub-block controls are registered alongside the state so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_MENU;
      score1     <= '0;
      score2     <= '0;
      won        <= 1'b0;
      game_reset <= 1'b1;
      game_run   <= 1'b0;
      cont_reset <= 1'b1;
      frame_cnt  <= '0;
    end else begin
      case (state)
        ST_MENU: begin
          if (enter_p) begin
            state      <= ST_PLAY;
            score1     <= '0;
            score2     <= '0;
            game_reset <= 1'b0;
            game_run   <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (bus.point_p1) begin
            score1     <= inc1;
            game_run   <= 1'b0;
            game_reset <= 1'b1;
            if (inc1 == WIN) begin
              won   <= 1'b0;
              state <= ST_OVER;
            end else begin
              state     <= ST_POINT;
              frame_cnt <= '0;
            end
          end else if (bus.point_p2) begin
            score2     <= inc2;
            game_run   <= 1'b0;
            game_reset <= 1'b1;
            if (inc2 == WIN) begin
              won   <= 1'b1;
              state <= ST_OVER;
            end else begin
              state     <= ST_POINT;
              frame_cnt <= '0;
            end
          end
        end
        ST_POINT: begin
          if (bus.frame_tick) begin
            if (frame_cnt == PAUSE_LAST) begin
              state      <= ST_PLAY;
              game_run   <= 1'b1;
              game_reset <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        ST_OVER: begin
          // Entry cycle keeps cont_reset high so the continue arrow starts on "yes".
          cont_reset <= 1'b0;
          if (bus.yes) begin
            state      <= ST_PLAY;
            score1     <= '0;
            score2     <= '0;
            game_reset <= 1'b0;
            game_run   <= 1'b1;
            cont_reset <= 1'b1;
          end else if (bus.no) begin
            state      <= ST_MENU;
            cont_reset <= 1'b1;
          end
        end
        default: state <= ST_MENU;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= BLACK;
    end else if (bus.p_tick) begin
      case (state)
        ST_MENU:           rgb <= bus.rgb_menu;
        ST_PLAY, ST_POINT: rgb <= bus.rgb_game;
        default:           rgb <= bus.rgb_continue;
      endcase
    end
  end

  assign bus.up_p       = up_p;
  assign bus.down_p     = down_p;
  assign bus.enter_p    = enter_p;
  assign bus.game_reset = game_reset;
  assign bus.game_run   = game_run;
  assign bus.cont_reset = cont_reset;
  assign bus.won        = won;
  assign bus.score1     = score1;
  assign bus.score2     = score2;
  assign bus.state      = state;
  assign bus.rgb        = rgb;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with WIN_SCORE=5 and PAUSE_FRAMES=3.
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  game_flow_ctrl_if bus ();

  game_flow_ctrl #(.WIN_SCORE(5), .PAUSE_FRAMES(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_enter();
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick();
  endtask

  task automatic point1();
    bus.point_p1 = 1'b1;
    tick();
    bus.point_p1 = 1'b0;
  endtask

  task automatic point2();
    bus.point_p2 = 1'b1;
    tick();
    bus.point_p2 = 1'b0;
  endtask

  task automatic pause_out();
    for (int i = 0; i < 3; i++) begin
      bus.frame_tick = 1'b1;
      tick();
      bus.frame_tick = 1'b0;
      tick();
    end
  endtask

  task automatic reach_over_p2();
    for (int i = 0; i < 4; i++) begin
      point2();
      pause_out();
    end
    point2();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (bus.state !== 2'b00) $display("FAIL rst_state: got %0h want 0", bus.state); else passed++;
    total++; if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0) $display("FAIL rst_scores: got %0d/%0d want 0/0", bus.score1, bus.score2); else passed++;
    total++; if (bus.game_reset !== 1'b1 || bus.cont_reset !== 1'b1) $display("FAIL rst_subresets: got %b%b want 11", bus.game_reset, bus.cont_reset); else passed++;
    total++; if (bus.game_run !== 1'b0 || bus.won !== 1'b0) $display("FAIL rst_run_won: got %b%b want 00", bus.game_run, bus.won); else passed++;
    total++; if (bus.rgb !== 12'h000) $display("FAIL rst_rgb: got %h want 000", bus.rgb); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_enter();
    int pulses = 0;
    int pulse_idx = -1;
    int play_idx = -1;
    logic gr_at_pulse = 1'b0;
    logic gr_at_play = 1'b1;
    bus.enter = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.enter_p === 1'b1) begin
        pulses++;
        if (pulse_idx < 0) begin pulse_idx = i; gr_at_pulse = bus.game_reset; end
      end
      if (bus.state === 2'b01 && play_idx < 0) begin play_idx = i; gr_at_play = bus.game_reset; end
    end
    bus.enter = 1'b0;
    tick();
    total++; if (pulses != 1) $display("FAIL enter_pulse_count: got %0d want 1", pulses); else passed++;
    total++; if (play_idx != pulse_idx + 1 || pulse_idx < 0) $display("FAIL enter_to_play: got idx %0d want %0d", play_idx, pulse_idx + 1); else passed++;
    total++; if (gr_at_pulse !== 1'b1 || gr_at_play !== 1'b0) $display("FAIL enter_game_reset: got %b->%b want 1->0", gr_at_pulse, gr_at_play); else passed++;
    total++; if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0 || bus.game_run !== 1'b1) $display("FAIL enter_play_outs: got %0d/%0d run %b want 0/0 run 1", bus.score1, bus.score2, bus.game_run); else passed++;
  endtask

  task automatic test_tie();
    bus.point_p1 = 1'b1;
    bus.point_p2 = 1'b1;
    tick();
    bus.point_p1 = 1'b0;
    bus.point_p2 = 1'b0;
    total++; if (bus.score1 !== 4'd1 || bus.score2 !== 4'd0) $display("FAIL tie_scores: got %0d/%0d want 1/0", bus.score1, bus.score2); else passed++;
    total++; if (bus.state !== 2'b10) $display("FAIL tie_state: got %0h want 2", bus.state); else passed++;
    pause_out();
    total++; if (bus.state !== 2'b01) $display("FAIL tie_resume: got %0h want 1", bus.state); else passed++;
  endtask

  task automatic test_point_pause();
    point1();
    total++; if (bus.state !== 2'b10 || bus.game_run !== 1'b0 || bus.game_reset !== 1'b1) $display("FAIL pt_enter: got st %0h run %b rst %b want 2 0 1", bus.state, bus.game_run, bus.game_reset); else passed++;
    total++; if (bus.score1 !== 4'd2) $display("FAIL pt_score1: got %0d want 2", bus.score1); else passed++;
    point2();
    total++; if (bus.score2 !== 4'd0) $display("FAIL pt_ignore_p2: got %0d want 0", bus.score2); else passed++;
    for (int i = 0; i < 3; i++) begin
      bus.frame_tick = 1'b1;
      tick();
      bus.frame_tick = 1'b0;
      total++; if (bus.state !== ((i < 2) ? 2'b10 : 2'b01)) $display("FAIL pt_frame%0d_state: got %0h want %0h", i, bus.state, (i < 2) ? 2'b10 : 2'b01); else passed++;
      total++; if (bus.game_run !== ((i < 2) ? 1'b0 : 1'b1)) $display("FAIL pt_frame%0d_run: got %b want %b", i, bus.game_run, (i < 2) ? 1'b0 : 1'b1); else passed++;
      tick();
    end
  endtask

  task automatic test_win();
    point1();
    pause_out();
    point1();
    pause_out();
    total++; if (bus.score1 !== 4'd4 || bus.state !== 2'b01) $display("FAIL win_pre: got %0d st %0h want 4 st 1", bus.score1, bus.state); else passed++;
    point1();
    total++; if (bus.state !== 2'b11 || bus.won !== 1'b0 || bus.score1 !== 4'd5) $display("FAIL win_over: got st %0h won %b s1 %0d want 3 0 5", bus.state, bus.won, bus.score1); else passed++;
    total++; if (bus.cont_reset !== 1'b1 || bus.game_reset !== 1'b1 || bus.game_run !== 1'b0) $display("FAIL win_entry_ctl: got %b%b%b want 110", bus.cont_reset, bus.game_reset, bus.game_run); else passed++;
    tick();
    total++; if (bus.cont_reset !== 1'b0) $display("FAIL win_cont_release: got %b want 0", bus.cont_reset); else passed++;
    press_enter();
    total++; if (bus.state !== 2'b11 || bus.won !== 1'b0) $display("FAIL over_enter_ignored: got st %0h won %b want 3 0", bus.state, bus.won); else passed++;
  endtask

  task automatic test_over_rgb();
    bus.rgb_menu     = 12'h0C3;
    bus.rgb_game     = 12'h0AB;
    bus.rgb_continue = 12'hF11;
    bus.p_tick = 1'b1;
    tick();
    bus.p_tick = 1'b0;
    total++; if (bus.rgb !== 12'hF11) $display("FAIL rgb_over: got %h want F11", bus.rgb); else passed++;
    bus.rgb_continue = 12'h123;
    tick();
    total++; if (bus.rgb !== 12'hF11) $display("FAIL rgb_hold: got %h want F11", bus.rgb); else passed++;
    bus.yes = 1'b1;
    tick();
    bus.yes = 1'b0;
    total++; if (bus.state !== 2'b01 || bus.score1 !== 4'd0 || bus.score2 !== 4'd0) $display("FAIL yes_restart: got st %0h %0d/%0d want 1 0/0", bus.state, bus.score1, bus.score2); else passed++;
    total++; if (bus.cont_reset !== 1'b1 || bus.game_reset !== 1'b0) $display("FAIL yes_ctl: got %b%b want 10", bus.cont_reset, bus.game_reset); else passed++;
    bus.p_tick = 1'b1;
    tick();
    bus.p_tick = 1'b0;
    total++; if (bus.rgb !== 12'h0AB) $display("FAIL rgb_play: got %h want 0AB", bus.rgb); else passed++;
  endtask

  task automatic test_p2_choices();
    reach_over_p2();
    total++; if (bus.state !== 2'b11 || bus.won !== 1'b1 || bus.score2 !== 4'd5 || bus.score1 !== 4'd0) $display("FAIL p2_win: got st %0h won %b %0d/%0d want 3 1 0/5", bus.state, bus.won, bus.score1, bus.score2); else passed++;
    bus.yes = 1'b1;
    bus.no  = 1'b1;
    tick();
    bus.yes = 1'b0;
    bus.no  = 1'b0;
    total++; if (bus.state !== 2'b01 || bus.score2 !== 4'd0) $display("FAIL yes_no_tie: got st %0h s2 %0d want 1 0", bus.state, bus.score2); else passed++;
    reach_over_p2();
    bus.no = 1'b1;
    tick();
    bus.no = 1'b0;
    total++; if (bus.state !== 2'b00 || bus.cont_reset !== 1'b1 || bus.game_reset !== 1'b1) $display("FAIL no_menu: got st %0h cr %b gr %b want 0 1 1", bus.state, bus.cont_reset, bus.game_reset); else passed++;
    bus.p_tick = 1'b1;
    tick();
    bus.p_tick = 1'b0;
    total++; if (bus.rgb !== 12'h0C3) $display("FAIL rgb_menu: got %h want 0C3", bus.rgb); else passed++;
  endtask

  task automatic test_reset_mid();
    press_enter();
    total++; if (bus.state !== 2'b01) $display("FAIL mid_play: got %0h want 1", bus.state); else passed++;
    point2();
    pause_out();
    point2();
    pause_out();
    point2();
    total++; if (bus.state !== 2'b10 || bus.score2 !== 4'd3) $display("FAIL mid_point: got st %0h s2 %0d want 2 3", bus.state, bus.score2); else passed++;
    bus.p_tick = 1'b1;
    tick();
    bus.p_tick = 1'b0;
    total++; if (bus.rgb !== 12'h0AB) $display("FAIL mid_rgb: got %h want 0AB", bus.rgb); else passed++;
    bus.enter = 1'b1;
    reset = 1'b1;
    tick();
    total++; if (bus.state !== 2'b00 || bus.score2 !== 4'd0) $display("FAIL mid_rst_state: got st %0h s2 %0d want 0 0", bus.state, bus.score2); else passed++;
    total++; if (bus.rgb !== 12'h000 || bus.game_reset !== 1'b1 || bus.enter_p !== 1'b0) $display("FAIL mid_rst_outs: got rgb %h gr %b ep %b want 000 1 0", bus.rgb, bus.game_reset, bus.enter_p); else passed++;
    bus.enter = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.p_tick = 1'b0;
    bus.frame_tick = 1'b0;
    bus.up1 = 1'b0;
    bus.down1 = 1'b0;
    bus.enter = 1'b0;
    bus.point_p1 = 1'b0;
    bus.point_p2 = 1'b0;
    bus.yes = 1'b0;
    bus.no = 1'b0;
    bus.rgb_menu = 12'h000;
    bus.rgb_game = 12'h000;
    bus.rgb_continue = 12'h000;
    test_reset();
    test_enter();
    test_tie();
    test_point_pause();
    test_win();
    test_over_rgb();
    test_p2_choices();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
